// File: rtl/ecdsa_pkg.sv
// ecdsa_pkg: shared constants, CSR map, table layout and sequencer states
package ecdsa_pkg;
  localparam int N_BITS = 381;
  localparam logic [N_BITS-1:0] P_BLS = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
  localparam logic [11:0] CSR_CMD = 12'h000;
  localparam logic [11:0] CSR_BASE_I = 12'h004;
  localparam logic [11:0] CSR_ARGC_I = 12'h008;
  localparam logic [11:0] CSR_BASE_O = 12'h00c;
  localparam logic [11:0] CSR_ARGC_O = 12'h010;
  localparam int IDX_A = 27;
  localparam int IDX_B = 26;
  localparam int IDX_R = 29;
  typedef enum logic [2:0] {IDLE, RD_TI, RD_A, RD_B, MUL, RD_TO, WR_R, DONE} state_t;
  function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++) old[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
    return old;
  endfunction
endpackage

// File: rtl/ecdsa_project_wrapper_mont.sv
// mont_mul_381: bit-serial radix-2 Montgomery multiplier, r = a*b*2^-N mod P
module mont_mul_381 import ecdsa_pkg::*; #(
  parameter int N = N_BITS,
  parameter logic [N-1:0] P = P_BLS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] r
);
  localparam int CW = $clog2(N + 1);
  logic [N-1:0] sa, sb;
  logic [N+1:0] t, s0, s1, d;
  logic [CW-1:0] cnt;
  logic busy;
  logic unused_ok;
  // one step: add a_i*b, add P when odd so the halving is exact
  always_comb begin
    s0 = t + (sa[0] ? {2'b0, sb} : '0);
    s1 = s0 + (s0[0] ? {2'b0, P} : '0);
    d = t - {2'b0, P};
  end
  assign done = busy && cnt == CW'(N);
  assign r = t >= {2'b0, P} ? d[N-1:0] : t[N-1:0];
  assign unused_ok = ^d[N+1:N];
  // iterate N steps; the final compare/subtract cycle raises done and t then holds
  always_ff @(posedge clk)
    if (rst) begin
      busy <= 1'b0;
      cnt <= '0;
      t <= '0;
      sa <= '0;
      sb <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      t <= '0;
      sa <= a;
      sb <= b;
    end else if (busy) begin
      if (done) busy <= 1'b0;
      else begin
        t <= s1 >> 1;
        sa <= sa >> 1;
        cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: rtl/ecdsa_project_wrapper.sv
// ecdsa_project_wrapper: AXI4-Lite CSRs, shared dual-port RAM and Montgomery multiply sequencer
module ecdsa_project_wrapper import ecdsa_pkg::*; #(
  parameter int N = N_BITS,
  parameter logic [N-1:0] P = P_BLS,
  parameter int MEM_WORDS = 32
) (
  input  logic          clk,
  input  logic          rst,
  output logic          leds,
  input  logic [11:0]   s_axi_csrs_awaddr,
  input  logic          s_axi_csrs_awvalid,
  output logic          s_axi_csrs_awready,
  input  logic [31:0]   s_axi_csrs_wdata,
  input  logic [3:0]    s_axi_csrs_wstrb,
  input  logic          s_axi_csrs_wvalid,
  output logic          s_axi_csrs_wready,
  output logic [1:0]    s_axi_csrs_bresp,
  output logic          s_axi_csrs_bvalid,
  input  logic          s_axi_csrs_bready,
  input  logic [11:0]   s_axi_csrs_araddr,
  input  logic          s_axi_csrs_arvalid,
  output logic          s_axi_csrs_arready,
  output logic [31:0]   s_axi_csrs_rdata,
  output logic [1:0]    s_axi_csrs_rresp,
  output logic          s_axi_csrs_rvalid,
  input  logic          s_axi_csrs_rready,
  input  logic [16:0]   mem_addr,
  input  logic [1023:0] mem_din,
  output logic [1023:0] mem_dout,
  input  logic          mem_en,
  input  logic          mem_rst,
  input  logic [127:0]  mem_we
);
  localparam int AW = $clog2(MEM_WORDS);
  logic [1023:0] mem [MEM_WORDS];
  logic [1023:0] core_q, core_wdata, wmask;
  logic [AW-1:0] core_addr, host_addr, ptr_a, ptr_b, ptr_r;
  logic [31:0] base_i, argc_i, base_o, argc_o, w_data, rd_data;
  logic [11:0] aw_addr;
  logic [3:0] w_strb;
  logic [N-1:0] op_a, mul_r;
  logic aw_got, w_got, wr_fire, cmd_start, cmd_clear, done, ph, core_we, mul_start, mul_done;
  logic unused_ok;
  state_t state, state_n;
  assign host_addr = mem_addr[7 +: AW];
  assign core_wdata = {mul_r, {(1024-N){1'b0}}};
  assign core_we = state == WR_R;
  assign mul_start = state == RD_B && ph;
  assign done = state == DONE;
  assign leds = done;
  assign wr_fire = aw_got && w_got && !s_axi_csrs_bvalid;
  assign cmd_start = wr_fire && aw_addr == CSR_CMD && w_data[0];
  assign cmd_clear = wr_fire && aw_addr == CSR_CMD && !w_data[0];
  assign s_axi_csrs_bresp = 2'b00;
  assign s_axi_csrs_rresp = 2'b00;
  assign unused_ok = ^{mem_addr, core_q, base_i, base_o};
  assign core_addr = state == RD_TI ? base_i[7 +: AW] : state == RD_A ? ptr_a : state == RD_B ? ptr_b :
                     state == RD_TO ? base_o[7 +: AW] : ptr_r;
  assign rd_data = s_axi_csrs_araddr == CSR_CMD ? {31'b0, done} : s_axi_csrs_araddr == CSR_BASE_I ? base_i :
                   s_axi_csrs_araddr == CSR_ARGC_I ? argc_i : s_axi_csrs_araddr == CSR_BASE_O ? base_o :
                   s_axi_csrs_araddr == CSR_ARGC_O ? argc_o : '0;
  // expand host byte enables into a bit mask
  always_comb begin
    wmask = '0;
    for (int i = 0; i < 128; i++) wmask[8*i +: 8] = {8{mem_we[i]}};
  end
  // shared RAM; the host write is applied last so it wins a same-word collision
  always_ff @(posedge clk) begin
    core_q <= rst ? '0 : mem[core_addr];
    if (core_we && !rst) mem[core_addr] <= core_wdata;
    if (mem_en && |mem_we) mem[host_addr] <= (mem[host_addr] & ~wmask) | (mem_din & wmask);
  end
  // host read port, registered
  always_ff @(posedge clk)
    if (rst || mem_rst) mem_dout <= '0;
    else if (mem_en) mem_dout <= mem[host_addr];
  // AXI write: accept AW and W independently, commit once both are held
  always_ff @(posedge clk)
    if (rst) begin
      s_axi_csrs_awready <= 1'b0;
      s_axi_csrs_wready <= 1'b0;
      s_axi_csrs_bvalid <= 1'b0;
      aw_got <= 1'b0;
      w_got <= 1'b0;
      aw_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
    end else begin
      s_axi_csrs_awready <= s_axi_csrs_awvalid && !s_axi_csrs_awready && !aw_got;
      s_axi_csrs_wready <= s_axi_csrs_wvalid && !s_axi_csrs_wready && !w_got;
      if (s_axi_csrs_awvalid && s_axi_csrs_awready) begin
        aw_got <= 1'b1;
        aw_addr <= s_axi_csrs_awaddr;
      end
      if (s_axi_csrs_wvalid && s_axi_csrs_wready) begin
        w_got <= 1'b1;
        w_data <= s_axi_csrs_wdata;
        w_strb <= s_axi_csrs_wstrb;
      end
      if (wr_fire) begin
        aw_got <= 1'b0;
        w_got <= 1'b0;
        s_axi_csrs_bvalid <= 1'b1;
      end else if (s_axi_csrs_bready) s_axi_csrs_bvalid <= 1'b0;
    end
  // byte-enabled CSR registers
  always_ff @(posedge clk)
    if (rst) begin
      base_i <= '0;
      argc_i <= '0;
      base_o <= '0;
      argc_o <= '0;
    end else if (wr_fire) begin
      if (aw_addr == CSR_BASE_I) base_i <= strb_merge(base_i, w_data, w_strb);
      if (aw_addr == CSR_ARGC_I) argc_i <= strb_merge(argc_i, w_data, w_strb);
      if (aw_addr == CSR_BASE_O) base_o <= strb_merge(base_o, w_data, w_strb);
      if (aw_addr == CSR_ARGC_O) argc_o <= strb_merge(argc_o, w_data, w_strb);
    end
  // AXI read: one-cycle arready pulse, rvalid held until rready
  always_ff @(posedge clk)
    if (rst) begin
      s_axi_csrs_arready <= 1'b0;
      s_axi_csrs_rvalid <= 1'b0;
      s_axi_csrs_rdata <= '0;
    end else begin
      s_axi_csrs_arready <= s_axi_csrs_arvalid && !s_axi_csrs_arready && !s_axi_csrs_rvalid;
      if (s_axi_csrs_arvalid && s_axi_csrs_arready) begin
        s_axi_csrs_rvalid <= 1'b1;
        s_axi_csrs_rdata <= rd_data;
      end else if (s_axi_csrs_rready) s_axi_csrs_rvalid <= 1'b0;
    end
  // sequencer state; ph marks the second (data-valid) cycle of a read state
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      ph <= 1'b0;
    end else begin
      state <= state_n;
      ph <= state_n == state ? !ph : 1'b0;
    end
  // next-state sequencing
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cmd_start) state_n = RD_TI;
      RD_TI:   if (ph) state_n = RD_A;
      RD_A:    if (ph) state_n = RD_B;
      RD_B:    if (ph) state_n = MUL;
      MUL:     if (mul_done) state_n = RD_TO;
      RD_TO:   if (ph) state_n = WR_R;
      WR_R:    state_n = DONE;
      DONE:    if (cmd_clear) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // capture table pointers and operand a as their words arrive
  always_ff @(posedge clk)
    if (rst) begin
      ptr_a <= '0;
      ptr_b <= '0;
      ptr_r <= '0;
      op_a <= '0;
    end else if (ph) begin
      if (state == RD_TI) begin
        ptr_a <= core_q[32*IDX_A+7 +: AW];
        ptr_b <= core_q[32*IDX_B+7 +: AW];
      end
      if (state == RD_A) op_a <= core_q[1023 -: N];
      if (state == RD_TO) ptr_r <= core_q[32*IDX_R+7 +: AW];
    end
  mont_mul_381 #(.N(N), .P(P)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(mul_start),
    .a(op_a),
    .b(core_q[1023 -: N]),
    .done(mul_done),
    .r(mul_r)
  );
endmodule

// File: tb/tb_ecdsa_project_wrapper.sv
// tb_ecdsa_project_wrapper: directed CSR/memory vectors and full Montgomery runs against a modular model
module tb_ecdsa_project_wrapper;
  localparam logic [380:0] PM = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
  localparam logic [380:0] VA = 381'h05da0d951f3c8a2e6b4d90c7a2f16e583b9d0c74e8a15f26c3d7049b5e82a1f3960d4c7b2a8e6f15d04b93c834c80df4;
  localparam logic [380:0] VB = 381'h0012efe19a4c3d72b81e6f05c7a29d345f0e81b6d293c74a0b6e5f18a4d7c29e73f1b8056c2d9ae41b8f5073d80f3dc8;
  logic clk = 1'b0, rst = 1'b1, leds;
  logic [11:0] awaddr = '0, araddr = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
  logic awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  logic [16:0] mem_addr = '0;
  logic [1023:0] mem_din = '0, mem_dout;
  logic mem_en = 1'b0, mem_rst = 1'b0;
  logic [127:0] mem_we = '0;
  int errs = 0, checks = 0;
  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } csr_vec_t;
  csr_vec_t vt [8];

  ecdsa_project_wrapper dut (
    .clk(clk), .rst(rst), .leds(leds),
    .s_axi_csrs_awaddr(awaddr), .s_axi_csrs_awvalid(awvalid), .s_axi_csrs_awready(awready),
    .s_axi_csrs_wdata(wdata), .s_axi_csrs_wstrb(wstrb), .s_axi_csrs_wvalid(wvalid), .s_axi_csrs_wready(wready),
    .s_axi_csrs_bresp(bresp), .s_axi_csrs_bvalid(bvalid), .s_axi_csrs_bready(bready),
    .s_axi_csrs_araddr(araddr), .s_axi_csrs_arvalid(arvalid), .s_axi_csrs_arready(arready),
    .s_axi_csrs_rdata(rdata), .s_axi_csrs_rresp(rresp), .s_axi_csrs_rvalid(rvalid), .s_axi_csrs_rready(rready),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_en(mem_en), .mem_rst(mem_rst), .mem_we(mem_we)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [380:0] ref_mont(input logic [380:0] a, input logic [380:0] b);
    logic [761:0] prod;
    logic [381:0] x;
    prod = {381'b0, a} * {381'b0, b};
    prod = prod % {381'b0, PM};
    x = {1'b0, prod[380:0]};
    for (int i = 0; i < 381; i++) x = x[0] ? (x + {1'b0, PM}) >> 1 : x >> 1;
    return x[380:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got hi=%h lo32=%h expected hi=%h lo32=%h", nm, act[1023:643], act[31:0], exp[1023:643], exp[31:0]);
    end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    logic ah, wh, bh;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bh = 1'b0;
    for (int n = 0; n < 20 && (awvalid || wvalid); n++) begin
      @(negedge clk); ah = awready; wh = wready;
      @(posedge clk); #1;
      if (ah) awvalid = 1'b0;
      if (wh) wvalid = 1'b0;
    end
    for (int n = 0; n < 20 && !bh; n++) begin
      @(negedge clk); bh = bvalid;
      @(posedge clk); #1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!bh) begin
      errs++; checks++;
      $display("FAIL axi_write_timeout: addr %h got no bvalid", a);
    end
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
    logic hs;
    araddr = a; arvalid = 1'b1; hs = 1'b0; d = '0;
    for (int n = 0; n < 20 && !hs; n++) begin
      @(negedge clk); hs = arready;
      @(posedge clk); #1;
    end
    arvalid = 1'b0; hs = 1'b0;
    for (int n = 0; n < 20 && !hs; n++) begin
      @(negedge clk); hs = rvalid;
      if (hs) d = rdata;
      @(posedge clk); #1;
    end
    if (!hs) begin
      errs++; checks++;
      $display("FAIL axi_read_timeout: addr %h got no rvalid", a);
    end
  endtask

  task automatic mem_write(input logic [16:0] a, input logic [1023:0] d, input logic [127:0] we);
    mem_addr = a; mem_din = d; mem_we = we; mem_en = 1'b1;
    @(posedge clk); #1;
    mem_en = 1'b0; mem_we = '0;
  endtask

  task automatic mem_read(input logic [16:0] a, output logic [1023:0] d);
    mem_addr = a; mem_we = '0; mem_en = 1'b1;
    @(posedge clk); #1;
    mem_en = 1'b0; d = mem_dout;
  endtask

  task automatic run_wait(input string nm);
    logic [31:0] st;
    logic ok;
    axi_write(12'h000, 32'h1, 4'hf);
    ok = 1'b0;
    for (int n = 0; n < 150 && !ok; n++) begin
      axi_read(12'h000, st);
      ok = st[0];
    end
    chk({nm, "_done"}, {31'b0, ok}, 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1023:0] w, pat1, pat2, sent;
    vt[0] = '{12'h004, 32'h0000_0200, 4'hf, 32'h0000_0200};
    vt[1] = '{12'h008, 32'h0000_0002, 4'hf, 32'h0000_0002};
    vt[2] = '{12'h010, 32'hffff_ffff, 4'h1, 32'h0000_00ff};
    vt[3] = '{12'h00c, 32'h0000_0300, 4'hf, 32'h0000_0300};
    vt[4] = '{12'h008, 32'haabb_ccdd, 4'ha, 32'haa00_cc02};
    vt[5] = '{12'h010, 32'h1234_5601, 4'h4, 32'h0034_00ff};
    vt[6] = '{12'h014, 32'hdead_beef, 4'hf, 32'h0000_0000};
    vt[7] = '{12'h008, 32'h0000_0002, 4'hf, 32'h0000_0002};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    axi_read(12'h000, rd);
    chk("reset_status", rd, 32'h0);
    chk("reset_leds", {31'b0, leds}, 32'h0);
    chk("reset_base_i", {31'b0, mem_dout != '0}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      axi_write(vt[i].addr, vt[i].data, vt[i].strb);
      axi_read(vt[i].addr, rd);
      chk($sformatf("csr_vec%0d", i), rd, vt[i].exp);
    end
    pat1 = {32{32'hc0ff_ee11}};
    pat2 = {32{32'h1234_5678}};
    mem_write(17'h080, pat1, '1);
    mem_read(17'h080, w);
    chk_w("mem_full_word", w, pat1);
    mem_write(17'h080, pat2, 128'hf);
    mem_read(17'h080, w);
    chk_w("mem_byte_we", w, {pat1[1023:32], pat2[31:0]});
    mem_write(17'h080, {VA, 643'b0}, '1);
    mem_write(17'h100, {VB, 643'b0}, '1);
    w = '0; w[32*27 +: 32] = 32'h80; w[32*26 +: 32] = 32'h100;
    mem_write(17'h200, w, '1);
    w = '0; w[32*29 +: 32] = 32'h280;
    mem_write(17'h300, w, '1);
    sent = {32{32'h5a5a_a5a5}};
    mem_write(17'h280, sent, '1);
    run_wait("run1");
    chk("run1_leds", {31'b0, leds}, 32'h1);
    mem_read(17'h280, w);
    chk_w("run1_result", w, {ref_mont(VA, VB), 643'b0});
    axi_write(12'h000, 32'h0, 4'hf);
    axi_read(12'h000, rd);
    chk("clear_status", rd, 32'h0);
    chk("clear_leds", {31'b0, leds}, 32'h0);
    mem_write(17'h280, sent, '1);
    axi_write(12'h000, 32'h1, 4'hf);
    repeat (100) @(posedge clk);
    #1 mem_write(17'h080, {VB, 643'b0}, '1);
    run_wait("busy_start");
    mem_read(17'h280, w);
    chk_w("busy_start_result", w, {ref_mont(VA, VB), 643'b0});
    axi_write(12'h000, 32'h0, 4'hf);
    mem_write(17'h080, '0, '1);
    mem_write(17'h280, sent, '1);
    run_wait("zero");
    mem_read(17'h280, w);
    chk_w("zero_result", w, '0);
    axi_write(12'h000, 32'h0, 4'hf);
    mem_write(17'h080, {PM - 381'd1, 643'b0}, '1);
    mem_write(17'h100, {PM - 381'd1, 643'b0}, '1);
    run_wait("pm1");
    mem_read(17'h280, w);
    chk_w("pm1_result", w, {ref_mont(PM - 381'd1, PM - 381'd1), 643'b0});
    axi_write(12'h000, 32'h0, 4'hf);
    mem_write(17'h080, {VA, 643'b0}, '1);
    mem_write(17'h100, {VB, 643'b0}, '1);
    mem_write(17'h280, sent, '1);
    axi_write(12'h000, 32'h1, 4'hf);
    repeat (196) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    axi_read(12'h000, rd);
    chk("rst_mid_status", rd, 32'h0);
    chk("rst_mid_leds", {31'b0, leds}, 32'h0);
    repeat (450) @(posedge clk);
    #1 mem_read(17'h280, w);
    chk_w("rst_mid_mem", w, sent);
    axi_read(12'h004, rd);
    chk("rst_mid_base_i", rd, 32'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
